encoder8x3_serial: RTL and testbench

Sequential 8-to-3 encoder: the inverse of the team's 3x8 decoder. It captures an 8-bit one-hot or multi-hot vector on a load strobe and emits the 3-bit index of every set bit, one index per valid/ready handshake, in priority order. It sits wherever a decoded line vector (interrupt lines, request lines) must be turned back into binary indices for downstream logic.

---
 rtl/encoder8x3_serial.sv | 102 ++++++++++
 tb/tb_encoder8x3_serial.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/encoder8x3_serial.sv
// Sequential 8-to-3 encoder. It captures a line vector on load and then
// emits the index of each set bit, one per valid/ready handshake, in priority order.
module encoder8x3_serial #(
    parameter bit PRIORITY_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] D,
    input  logic       load,
    input  logic       ready,
    output logic [2:0] Y,
    output logic       valid,
    output logic       last,
    output logic       busy,
    output logic       done,
    output logic       none,
    output logic [3:0] count
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] pending;
    logic [2:0] head_idx;
    logic       single;

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
        return n;
    endfunction

    // Later loop iterations overwrite earlier ones, so the scan order decides the winner.
    function automatic logic [2:0] priority_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (PRIORITY_HIGH) begin
            for (int i = 0; i < 8; i++) if (v[i]) idx = 3'(i);
        end else begin
            for (int i = 7; i >= 0; i--) if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // NOTE: every always_comb output gets a default first so that no path leaves it unassigned (no latch).
    always_comb begin
        head_idx = 3'd0;
        single   = 1'b0;
        if (state == EMIT) begin
            head_idx = priority_index(pending);
            single   = (pending != 8'd0) && ((pending & 8'(pending - 8'd1)) == 8'd0);
        end
    end

    assign valid = (state == EMIT);
    assign busy  = (state == EMIT);
    assign Y     = head_idx;
    assign last  = single;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= 8'd0;
            count   <= 4'd0;
            done    <= 1'b0;
            none    <= 1'b0;
        end else begin
            done <= 1'b0;
            none <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        pending <= D;
                        count   <= popcount(D);
                        if (D != 8'd0) begin
                            state <= EMIT;
                        end else begin
                            none <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    // Load is ignored here, including on the final handshake.
                    if (ready) begin
                        pending[head_idx] <= 1'b0;
                        if (single) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder8x3_serial.sv
// Bench for encoder8x3_serial: both priority orders side by side, checked every
// cycle against an index-list model, plus directed scenarios with literal expectations.
module tb_encoder8x3_serial;

    logic       clk;
    logic       rst_n;
    logic [7:0] D;
    logic       load;
    logic       ready;

    logic [2:0] y_o     [2];
    logic       valid_o [2];
    logic       last_o  [2];
    logic       busy_o  [2];
    logic       done_o  [2];
    logic       none_o  [2];
    logic [3:0] count_o [2];

    int total = 0;
    int bad   = 0;

    // Model per instance: ordered list of indices still to emit.
    logic [2:0] m_list [2][8];
    int         m_head [2];
    int         m_len  [2];
    int         m_cnt  [2];
    logic       m_done [2];
    logic       m_none [2];

    encoder8x3_serial #(.PRIORITY_HIGH(1'b1)) dut_hi (
        .clk(clk), .rst_n(rst_n), .D(D), .load(load), .ready(ready),
        .Y(y_o[0]), .valid(valid_o[0]), .last(last_o[0]), .busy(busy_o[0]),
        .done(done_o[0]), .none(none_o[0]), .count(count_o[0])
    );

    encoder8x3_serial #(.PRIORITY_HIGH(1'b0)) dut_lo (
        .clk(clk), .rst_n(rst_n), .D(D), .load(load), .ready(ready),
        .Y(y_o[1]), .valid(valid_o[1]), .last(last_o[1]), .busy(busy_o[1]),
        .done(done_o[1]), .none(none_o[1]), .count(count_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_head[i] = 0;
            m_len[i]  = 0;
            m_cnt[i]  = 0;
            m_done[i] = 1'b0;
            m_none[i] = 1'b0;
        end
    endtask

    task automatic model_step(input logic ld, input logic [7:0] d, input logic rdy);
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 1'b0;
            m_none[i] = 1'b0;
            if (m_head[i] < m_len[i]) begin
                if (rdy) begin
                    m_head[i]++;
                    if (m_head[i] == m_len[i]) m_done[i] = 1'b1;
                end
            end else if (ld) begin
                m_head[i] = 0;
                m_len[i]  = 0;
                m_cnt[i]  = $countones(d);
                if (d == 8'd0) m_none[i] = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    int b;
                    b = (i == 0) ? 7 - k : k;
                    if (d[b]) begin
                        m_list[i][m_len[i]] = 3'(b);
                        m_len[i]++;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            int ev, ey, el;
            ev = (m_head[i] < m_len[i]) ? 1 : 0;
            ey = ev ? int'(m_list[i][m_head[i]]) : 0;
            el = (ev != 0 && (m_len[i] - m_head[i]) == 1) ? 1 : 0;
            check($sformatf("valid[%0d]", i), int'(valid_o[i]), ev);
            check($sformatf("busy[%0d]", i),  int'(busy_o[i]),  ev);
            check($sformatf("Y[%0d]", i),     int'(y_o[i]),     ey);
            check($sformatf("last[%0d]", i),  int'(last_o[i]),  el);
            check($sformatf("done[%0d]", i),  int'(done_o[i]),  int'(m_done[i]));
            check($sformatf("none[%0d]", i),  int'(none_o[i]),  int'(m_none[i]));
            check($sformatf("count[%0d]", i), int'(count_o[i]), m_cnt[i]);
        end
    endtask

    // Called at a falling edge: drive, let one rising edge pass, compare at the next falling edge.
    task automatic cycle(input logic ld, input logic [7:0] d, input logic rdy);
        load  = ld;
        D     = d;
        ready = rdy;
        model_step(ld, d, rdy);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        D     = 8'd0;
        ready = 1'b0;
        model_reset();
        @(negedge clk);
        compare_all();
        check("reset_valid", int'(valid_o[0]), 0);
        rst_n = 1'b1;

        // 8'b1010_0100: high-first gives 7,5,2; low-first gives 2,5,7.
        cycle(1'b1, 8'hA4, 1'b1);
        check("a4_y0_hi", int'(y_o[0]), 7);
        check("a4_y0_lo", int'(y_o[1]), 2);
        cycle(1'b0, 8'h00, 1'b1);
        check("a4_y1_hi", int'(y_o[0]), 5);
        cycle(1'b0, 8'h00, 1'b1);
        check("a4_y2_hi", int'(y_o[0]), 2);
        check("a4_last_hi", int'(last_o[0]), 1);
        cycle(1'b0, 8'h00, 1'b1);
        check("a4_done_hi", int'(done_o[0]), 1);
        check("a4_count", int'(count_o[0]), 3);
        cycle(1'b0, 8'h00, 1'b1);

        // All ones: eight indices, one per cycle.
        cycle(1'b1, 8'hFF, 1'b1);
        for (int k = 0; k < 8; k++) cycle(1'b0, 8'h00, 1'b1);
        check("ff_done_lo", int'(done_o[1]), 1);
        check("ff_count", int'(count_o[1]), 8);
        cycle(1'b0, 8'h00, 1'b0);

        // Backpressure: index 4 must hold through four stalled cycles.
        cycle(1'b1, 8'h12, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b0, 8'h00, 1'b0);
        check("bp_hold_hi", int'(y_o[0]), 4);
        cycle(1'b0, 8'h00, 1'b1);
        check("bp_second_hi", int'(y_o[0]), 1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Zero load pulses none only.
        cycle(1'b1, 8'h00, 1'b1);
        check("zero_none", int'(none_o[0]), 1);
        cycle(1'b0, 8'h00, 1'b1);
        check("zero_none_off", int'(none_o[0]), 0);

        // Loads while busy (including on the final handshake) are ignored.
        cycle(1'b1, 8'h03, 1'b1);
        cycle(1'b1, 8'h80, 1'b1);
        cycle(1'b1, 8'h80, 1'b1);
        check("busy_load_count", int'(count_o[0]), 2);
        check("busy_load_valid", int'(valid_o[0]), 0);
        // Earliest next load while done is high.
        cycle(1'b1, 8'h40, 1'b0);
        check("next_load_y", int'(y_o[0]), 6);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);

        // Asynchronous reset mid-emit discards pending indices.
        cycle(1'b1, 8'hF0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_valid", int'(valid_o[0]), 0);
        check("rst_busy", int'(busy_o[0]), 0);
        check("rst_y", int'(y_o[0]), 0);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        cycle(1'b1, 8'h01, 1'b1);
        check("post_rst_y", int'(y_o[0]), 0);
        check("post_rst_last", int'(last_o[0]), 1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            logic       ld, rdy;
            logic [7:0] d;
            ld  = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            d   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            cycle(ld, d, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
